uart_ctrl: RTL
==============

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter POLL_GAP, default 4, idle cycles inserted after a status poll that finds the requested direction not ready (0 = none).
REQ-002 SHALL have ports clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have ports rstn  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports rx_req  in  1  level, request one received byte; rx_done  out  1  one-cycle completion pulse; rx_data  out  8  received byte.
REQ-005 SHALL have ports tx_req  in  1  level, request one byte transmit; tx_data  in  8  byte to send, stable while tx_req high; tx_done  out  1  one-cycle completion pulse.
REQ-006 SHALL have AXI4-lite read ports uart_axi_araddr out 4, uart_axi_arvalid out 1, uart_axi_arready in 1, uart_axi_rdata in 32, uart_axi_rresp in 2, uart_axi_rvalid in 1, uart_axi_rready out 1.
REQ-007 SHALL have AXI4-lite write ports uart_axi_awaddr out 4, uart_axi_awvalid out 1, uart_axi_awready in 1, uart_axi_wdata out 32, uart_axi_wstrb out 4, uart_axi_wvalid out 1, uart_axi_wready in 1, uart_axi_bresp in 2, uart_axi_bvalid in 1, uart_axi_bready out 1.
REQ-008 SHALL have port err  out  1  sticky AXI error flag.

Function
REQ-009 SHALL use register map: 0x0 RX FIFO, 0x4 TX FIFO, 0x8 STATUS (bit0 rx valid, bit3 tx full).
REQ-010 SHALL implement states IDLE, STAT_AR, STAT_R, DATA_AR, DATA_R, WR, WR_B, GAP.
REQ-011 SHALL in IDLE, when any request is high, grant one direction and go to STAT_AR next cycle; with both high, grant the direction not granted last (round-robin, rx preferred after reset).
REQ-012 SHALL in STAT_AR drive araddr=0x8, arvalid=1 until arready sampled high, then go to STAT_R with arvalid=0.
REQ-013 SHALL hold rready=1 throughout STAT_R and DATA_R; read completes on the cycle rvalid is high.
REQ-014 SHALL from STAT_R: rx grant with rdata[0]=1 -> DATA_AR; tx grant with rdata[3]=0 -> WR; otherwise -> GAP.
REQ-015 SHALL in DATA_AR drive araddr=0x0 with arvalid handshake as REQ-012, then DATA_R; on rvalid latch rdata[7:0] into rx_data, pulse rx_done, return to IDLE.
REQ-016 SHALL in WR drive awaddr=0x4, wdata={24'b0,tx_data}, wstrb=4'b0001, awvalid and wvalid together; each valid drops independently after its own ready; go to WR_B when both handshakes done (same or different cycles).
REQ-017 SHALL in WR_B hold bready=1; on bvalid pulse tx_done and return to IDLE.
REQ-018 SHALL in GAP count POLL_GAP cycles (0 = single pass-through cycle omitted, direct to IDLE) then return to IDLE and re-arbitrate.
REQ-019 SHALL sample requests only in IDLE; a granted transaction completes and pulses done even if its request drops mid-operation.
REQ-020 SHALL keep rx_data unchanged except on rx_done; at most one done pulse per cycle; never assert done in two consecutive cycles for the same direction.
REQ-021 SHALL never have more than one AXI transaction outstanding.

Reset
REQ-022 SHALL on rstn low immediately force state IDLE, all valid/ready outputs 0, rx_done=tx_done=0, rx_data=0, err=0, gap counter 0, round-robin to rx; addresses/wdata 0.
REQ-023 SHALL on reset mid-transaction abandon it without issuing done.

Configuration
REQ-024 SHALL with UART_CTRL_ERR_EN defined set err when any rresp or bresp handshake carries nonzero response, cleared only by reset; data-path flow unchanged.
REQ-025 SHALL without UART_CTRL_ERR_EN tie err to 0 and ignore rresp/bresp.

Verification
REQ-026 rx_req=1, slave status 0x01 then RX 0x5A -> araddr 0x8 then 0x0, rx_data=0x5A with one rx_done pulse.
REQ-027 tx_req=1, tx_data=0xC3, status 0x00 -> awaddr 0x4, wdata 0x000000C3, wstrb 0x1, one tx_done after bvalid.
REQ-028 rx_req=1, status 0x00 twice then 0x01, POLL_GAP=4 -> three status reads, 4-cycle gaps between, then data read.
REQ-029 rx_req and tx_req both held, ready status -> grants alternate rx, tx, rx; done pulses alternate.
REQ-030 wready 3 cycles after awready -> wvalid held until wready, single write; rstn low during WR_B -> all valids 0 same cycle, no tx_done.
REQ-031 macro defined, rresp=2'b10 on status read -> err=1 and stays 1; macro undefined -> err=0.

Source files
------------

// File: rtl/uart_ctrl.sv
// UART bridge: turns rx/tx byte requests into AXI4-lite polls and FIFO accesses.
// Define UART_CTRL_ERR_EN to latch nonzero rresp/bresp into a sticky err flag.
module uart_ctrl #(
    parameter int unsigned POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_req,
    output logic        rx_done,
    output logic [7:0]  rx_data,
    input  logic        tx_req,
    input  logic [7:0]  tx_data,
    output logic        tx_done,
    output logic [3:0]  uart_axi_araddr,
    output logic        uart_axi_arvalid,
    input  logic        uart_axi_arready,
    input  logic [31:0] uart_axi_rdata,
    input  logic [1:0]  uart_axi_rresp,
    input  logic        uart_axi_rvalid,
    output logic        uart_axi_rready,
    output logic [3:0]  uart_axi_awaddr,
    output logic        uart_axi_awvalid,
    input  logic        uart_axi_awready,
    output logic [31:0] uart_axi_wdata,
    output logic [3:0]  uart_axi_wstrb,
    output logic        uart_axi_wvalid,
    input  logic        uart_axi_wready,
    input  logic [1:0]  uart_axi_bresp,
    input  logic        uart_axi_bvalid,
    output logic        uart_axi_bready,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, STAT_AR, STAT_R, DATA_AR, DATA_R, WR, WR_B, GAP
    } state_t;

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic          grant_tx;
    logic          last_tx;
    logic          pick_tx;
    logic          aw_ok;
    logic          w_ok;

    // last_tx resets high so rx wins the first contested arbitration
    assign pick_tx = tx_req && (!rx_req || !last_tx);
    assign aw_ok   = !uart_axi_awvalid || uart_axi_awready;
    assign w_ok    = !uart_axi_wvalid || uart_axi_wready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            gap_cnt          <= '0;
            grant_tx         <= 1'b0;
            last_tx          <= 1'b1;
            rx_done          <= 1'b0;
            tx_done          <= 1'b0;
            rx_data          <= 8'h00;
            uart_axi_araddr  <= 4'h0;
            uart_axi_arvalid <= 1'b0;
            uart_axi_rready  <= 1'b0;
            uart_axi_awaddr  <= 4'h0;
            uart_axi_awvalid <= 1'b0;
            uart_axi_wdata   <= 32'h0;
            uart_axi_wstrb   <= 4'h0;
            uart_axi_wvalid  <= 1'b0;
            uart_axi_bready  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_req || tx_req) begin
                        grant_tx         <= pick_tx;
                        last_tx          <= pick_tx;
                        uart_axi_araddr  <= 4'h8;
                        uart_axi_arvalid <= 1'b1;
                        state            <= STAT_AR;
                    end
                end
                STAT_AR: begin
                    if (uart_axi_arready) begin
                        uart_axi_arvalid <= 1'b0;
                        uart_axi_rready  <= 1'b1;
                        state            <= STAT_R;
                    end
                end
                STAT_R: begin
                    if (uart_axi_rvalid) begin
                        uart_axi_rready <= 1'b0;
                        if (!grant_tx && uart_axi_rdata[0]) begin
                            uart_axi_araddr  <= 4'h0;
                            uart_axi_arvalid <= 1'b1;
                            state            <= DATA_AR;
                        end else if (grant_tx && !uart_axi_rdata[3]) begin
                            uart_axi_awaddr  <= 4'h4;
                            uart_axi_wdata   <= {24'h0, tx_data};
                            uart_axi_wstrb   <= 4'b0001;
                            uart_axi_awvalid <= 1'b1;
                            uart_axi_wvalid  <= 1'b1;
                            state            <= WR;
                        end else if (POLL_GAP == 0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
                end
                DATA_AR: begin
                    if (uart_axi_arready) begin
                        uart_axi_arvalid <= 1'b0;
                        uart_axi_rready  <= 1'b1;
                        state            <= DATA_R;
                    end
                end
                DATA_R: begin
                    if (uart_axi_rvalid) begin
                        uart_axi_rready <= 1'b0;
                        rx_data         <= uart_axi_rdata[7:0];
                        rx_done         <= 1'b1;
                        state           <= IDLE;
                    end
                end
                WR: begin
                    if (uart_axi_awready) uart_axi_awvalid <= 1'b0;
                    if (uart_axi_wready)  uart_axi_wvalid  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        uart_axi_bready <= 1'b1;
                        state           <= WR_B;
                    end
                end
                WR_B: begin
                    if (uart_axi_bvalid) begin
                        uart_axi_bready <= 1'b0;
                        tx_done         <= 1'b1;
                        state           <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_bits;

`ifdef UART_CTRL_ERR_EN
    assign unused_bits = ^uart_axi_rdata[31:8];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if ((uart_axi_rvalid && uart_axi_rready &&
                      uart_axi_rresp != 2'b00) ||
                     (uart_axi_bvalid && uart_axi_bready &&
                      uart_axi_bresp != 2'b00)) begin
            err <= 1'b1;
        end
    end
`else
    assign unused_bits = ^{uart_axi_rdata[31:8], uart_axi_rresp,
                           uart_axi_bresp};
    assign err = 1'b0;
`endif

endmodule
